// File: rtl/data_proc_mmio_fifo.sv
// Purpose : memory-mapped front end for the pixel processor; start/mode control, output pixel FIFO
//           popped through a DATA register, frame-length counting, sticky done, irq, soft clear.
// Latency : bus access acked one cycle after selection (one wait state); mem_rdata registered.
// Backpr. : s_ready drops when the FIFO is full, the frame is complete, or the block is not running.
// Ports   : clk/resetn (sync, active-low); mem_* rvsoc slave bus; proc_start/proc_mode to processor;
//           s_valid/s_ready/s_data pixel stream from processor; irq level interrupt.
module data_proc_mmio_fifo #(
  parameter logic [31:0] BASE_ADDR    = 32'h0200_1000,
  parameter int          PIX_W        = 8,
  parameter int          MODE_W       = 2,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          FRAME_PIXELS = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              proc_start,
  output logic [MODE_W-1:0] proc_mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PIX_W-1:0]  s_data,
  output logic              irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  logic [MODE_W-1:0] r_mode;
  logic              r_irq_en;
  logic              r_done;
  logic              r_underflow;
  logic [31:0]       r_pix_cnt;
  logic [31:0]       r_frame_len;
  logic [PIX_W-1:0]  r_fifo [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;

  logic [31:0] w_off;
  logic        w_sel, w_acc, w_wr;
  logic        w_ctl_wr, w_st_wr, w_fl_wr, w_dat_rd, w_clear;
  logic        w_busy, w_full, w_empty;
  logic        w_accept, w_push, w_pop, w_cnt_hit;
  logic [31:0] w_rd_val;

  // Offset arithmetic wraps, so addresses below BASE_ADDR land far out of range.
  assign w_off    = mem_addr - BASE_ADDR;
  assign w_sel    = mem_valid && (w_off <= 32'h10) && (w_off[1:0] == 2'b00);
  // Only the first selected cycle acts; the cycle with mem_ready high is the ack cycle.
  assign w_acc    = w_sel && !mem_ready;
  assign w_wr     = |mem_wstrb;
  assign w_ctl_wr = w_acc &&  w_wr && (w_off[4:2] == 3'd0);
  assign w_st_wr  = w_acc &&  w_wr && (w_off[4:2] == 3'd1);
  assign w_dat_rd = w_acc && !w_wr && (w_off[4:2] == 3'd3);
  assign w_fl_wr  = w_acc &&  w_wr && (w_off[4:2] == 3'd4);
  assign w_clear  = w_ctl_wr && mem_wdata[9];

  assign w_busy   = (r_state == S_RUN);
  assign w_full   = (r_level == (AW+1)'(FIFO_DEPTH));
  assign w_empty  = (r_level == '0);

  assign s_ready   = w_busy && !w_full && (r_pix_cnt < r_frame_len);
  assign w_accept  = s_valid && s_ready;
  // A soft clear in the same cycle discards the pixel the processor just handed over.
  assign w_push    = w_accept && !w_clear;
  assign w_pop     = w_dat_rd && !w_empty;
  assign w_cnt_hit = w_accept && ((r_pix_cnt + 32'd1) == r_frame_len);

  assign proc_start = w_busy;
  assign proc_mode  = r_mode;
  assign irq        = r_irq_en && r_done;

  always_comb begin
    w_rd_val = '0;
    case (w_off[4:2])
      3'd0: begin
        w_rd_val[0]        = (r_state != S_IDLE);
        w_rd_val[MODE_W:1] = r_mode;
        w_rd_val[8]        = r_irq_en;
      end
      3'd1: w_rd_val = {16'(r_level), 11'd0, r_underflow, r_done, w_full, !w_empty, w_busy};
      3'd2: w_rd_val = r_pix_cnt;
      3'd3: begin
        if (!w_empty) begin
          w_rd_val[31]        = 1'b1;
          w_rd_val[PIX_W-1:0] = r_fifo[r_rd_ptr];
        end
      end
      3'd4: w_rd_val = r_frame_len;
      default: w_rd_val = '0;
    endcase
  end

  // Storage has no reset; validity is carried entirely by the pointers and level.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_ready   <= 1'b0;
      mem_rdata   <= '0;
      r_state     <= S_IDLE;
      r_mode      <= '0;
      r_irq_en    <= 1'b0;
      r_done      <= 1'b0;
      r_underflow <= 1'b0;
      r_pix_cnt   <= '0;
      r_frame_len <= 32'(FRAME_PIXELS);
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
    end else begin
      mem_ready <= w_acc;
      mem_rdata <= w_acc ? w_rd_val : '0;

      if (w_ctl_wr) begin
        r_irq_en <= mem_wdata[8];
        if (!w_busy) r_mode <= mem_wdata[MODE_W:1];
      end
      if (w_fl_wr && !w_busy) r_frame_len <= mem_wdata;

      if (w_clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + 1'b1;
          2'b01:   r_level <= r_level - 1'b1;
          default: r_level <= r_level;
        endcase
      end

      if (w_clear)                      r_underflow <= 1'b0;
      else if (w_dat_rd && w_empty)     r_underflow <= 1'b1;
      else if (w_st_wr && mem_wdata[4]) r_underflow <= 1'b0;

      if (w_clear) begin
        r_state   <= S_IDLE;
        r_pix_cnt <= '0;
        r_done    <= 1'b0;
      end else begin
        if (w_accept) r_pix_cnt <= r_pix_cnt + 32'd1;
        // Setting done takes priority over a simultaneous W1C.
        if (w_cnt_hit)                    r_done <= 1'b1;
        else if (w_st_wr && mem_wdata[3]) r_done <= 1'b0;

        case (r_state)
          S_IDLE, S_DONE: begin
            if (w_ctl_wr && mem_wdata[0] && (r_frame_len != 32'd0)) begin
              r_state   <= S_RUN;
              r_pix_cnt <= '0;
              r_done    <= 1'b0;
            end else if (w_ctl_wr && !mem_wdata[0]) begin
              r_state <= S_IDLE;
            end
          end
          S_RUN: begin
            // start=1 while running is a no-op; start=0 aborts to idle keeping FIFO and count.
            if (w_ctl_wr && !mem_wdata[0]) r_state <= S_IDLE;
            else if (w_cnt_hit)            r_state <= S_DONE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_proc_mmio_fifo.sv
// Purpose : directed self-checking bench for data_proc_mmio_fifo (register table + frame sequences).
// Latency : each bus access takes two cycles (request, one-cycle ack).
// Backpr. : pixel source holds s_valid and counts cycles where s_ready was high.
module tb_data_proc_mmio_fifo;

  localparam logic [31:0] BASE = 32'h0200_1000;
  localparam logic [31:0] CTRL = 32'h00;
  localparam logic [31:0] STAT = 32'h04;
  localparam logic [31:0] PCNT = 32'h08;
  localparam logic [31:0] DATA = 32'h0C;
  localparam logic [31:0] FLEN = 32'h10;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [3:0]  mem_wstrb = 4'h0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic        proc_start;
  logic [1:0]  proc_mode;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h0;
  logic        irq;

  int checks = 0;
  int failures = 0;

  data_proc_mmio_fifo dut (
    .clk        (clk),
    .resetn     (resetn),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_wstrb  (mem_wstrb),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .proc_start (proc_start),
    .proc_mode  (proc_mode),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] off;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tab [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic bus(input logic wr, input logic [31:0] off, input logic [31:0] wd,
                     output logic [31:0] rd);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = BASE + off;
    mem_wstrb = wr ? 4'hF : 4'h0;
    mem_wdata = wd;
    @(posedge clk);
    #1;
    chk("bus_ready", {31'd0, mem_ready}, 32'd1);
    rd = mem_rdata;
    @(negedge clk);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string nm);
    logic [31:0] v;
    bus(1'b0, off, 32'h0, v);
    chk(nm, v, exp);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] wd);
    logic [31:0] v;
    bus(1'b1, off, wd, v);
  endtask

  // Offers one pixel per cycle for ncyc cycles; data increments only on acceptance.
  task automatic run_pix(input int ncyc, input logic [7:0] base, output int acc);
    acc = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = base + 8'(acc);
      if (s_ready) acc++;
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  initial begin
    int acc;
    logic [31:0] v;

    tab[0]  = '{1'b0, STAT, 32'h0,   1'b1, 32'h0000_0000};
    tab[1]  = '{1'b0, FLEN, 32'h0,   1'b1, 32'h0000_0400};
    tab[2]  = '{1'b0, PCNT, 32'h0,   1'b1, 32'h0000_0000};
    tab[3]  = '{1'b0, CTRL, 32'h0,   1'b1, 32'h0000_0000};
    tab[4]  = '{1'b1, FLEN, 32'h4,   1'b0, 32'h0};
    tab[5]  = '{1'b0, FLEN, 32'h0,   1'b1, 32'h0000_0004};
    tab[6]  = '{1'b1, CTRL, 32'h6,   1'b0, 32'h0};
    tab[7]  = '{1'b0, CTRL, 32'h0,   1'b1, 32'h0000_0006};
    tab[8]  = '{1'b1, CTRL, 32'h1,   1'b0, 32'h0};
    tab[9]  = '{1'b0, CTRL, 32'h0,   1'b1, 32'h0000_0001};
    tab[10] = '{1'b0, STAT, 32'h0,   1'b1, 32'h0000_0001};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_proc_start", {31'd0, proc_start}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Ack is a single-cycle pulse even with mem_valid held; rdata zero outside the ack.
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = BASE + FLEN;
    @(posedge clk); #1;
    chk("pulse_ready_hi", {31'd0, mem_ready}, 32'd1);
    chk("pulse_rdata", mem_rdata, 32'h400);
    @(posedge clk); #1;
    chk("pulse_ready_lo", {31'd0, mem_ready}, 32'd0);
    chk("pulse_rdata_lo", mem_rdata, 32'd0);
    @(negedge clk);
    mem_valid = 1'b0;

    // Unmapped and misaligned addresses are never acknowledged.
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = BASE + 32'h14;
    @(posedge clk); #1;
    chk("unmapped_ready", {31'd0, mem_ready}, 32'd0);
    @(negedge clk);
    mem_addr = BASE + 32'h2;
    @(posedge clk); #1;
    chk("misaligned_ready", {31'd0, mem_ready}, 32'd0);
    @(negedge clk);
    mem_valid = 1'b0;

    for (int i = 0; i < 11; i++) begin
      bus(tab[i].wr, tab[i].off, tab[i].wd, v);
      if (tab[i].chk) chk($sformatf("tab%0d", i), v, tab[i].exp);
    end
    chk("run_proc_start", {31'd0, proc_start}, 32'd1);
    chk("run_proc_mode", {30'd0, proc_mode}, 32'd0);

    // Four-pixel frame.
    run_pix(8, 8'h11, acc);
    chk("f4_accepted", acc, 32'd4);
    chk("f4_proc_start", {31'd0, proc_start}, 32'd0);
    rd(PCNT, 32'd4, "f4_pixcnt");
    rd(STAT, 32'h0004_000A, "f4_status");
    rd(DATA, 32'h8000_0011, "f4_pop0");
    rd(DATA, 32'h8000_0012, "f4_pop1");
    rd(DATA, 32'h8000_0013, "f4_pop2");
    rd(DATA, 32'h8000_0014, "f4_pop3");
    rd(DATA, 32'h0000_0000, "empty_pop");
    rd(STAT, 32'h0000_0018, "underflow_set");
    wr(STAT, 32'h10);
    rd(STAT, 32'h0000_0008, "underflow_w1c");
    rd(CTRL, 32'h0000_0001, "done_start_rb");

    // Interrupt on a two-pixel frame.
    wr(CTRL, 32'h0);
    wr(FLEN, 32'd2);
    wr(CTRL, 32'h101);
    chk("irq_before", {31'd0, irq}, 32'd0);
    run_pix(5, 8'h21, acc);
    chk("f2_accepted", acc, 32'd2);
    chk("irq_set", {31'd0, irq}, 32'd1);
    rd(STAT, 32'h0002_000A, "f2_status");
    wr(STAT, 32'h08);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    rd(STAT, 32'h0002_0002, "done_w1c");
    rd(DATA, 32'h8000_0021, "f2_pop0");
    rd(DATA, 32'h8000_0022, "f2_pop1");

    // start with FRAME_LEN=0 is ignored.
    wr(CTRL, 32'h0);
    wr(FLEN, 32'd0);
    wr(CTRL, 32'h1);
    rd(CTRL, 32'h0, "zero_len_ctrl");
    rd(STAT, 32'h0, "zero_len_status");

    // FIFO fills at 16 on a 20-pixel frame; one pop frees exactly one slot.
    wr(FLEN, 32'd20);
    wr(CTRL, 32'h1);
    run_pix(25, 8'h40, acc);
    chk("full_accepted", acc, 32'd16);
    chk("full_s_ready", {31'd0, s_ready}, 32'd0);
    rd(STAT, 32'h0010_0007, "full_status");
    wr(CTRL, 32'h7);
    rd(CTRL, 32'h1, "busy_mode_ignored");
    chk("busy_proc_mode", {30'd0, proc_mode}, 32'd0);
    rd(PCNT, 32'd16, "restart_ignored");
    rd(DATA, 32'h8000_0040, "full_pop");
    run_pix(10, 8'h50, acc);
    chk("after_pop_accepted", acc, 32'd1);
    rd(PCNT, 32'd17, "after_pop_pixcnt");
    rd(STAT, 32'h0010_0007, "refull_status");

    // Soft clear mid-frame.
    wr(CTRL, 32'h200);
    rd(STAT, 32'h0, "clear_full_status");
    wr(FLEN, 32'd10);
    wr(CTRL, 32'h1);
    run_pix(3, 8'h60, acc);
    chk("mid_accepted", acc, 32'd3);
    rd(STAT, 32'h0003_0003, "mid_status");
    wr(CTRL, 32'h201);
    rd(STAT, 32'h0, "clear_status");
    rd(PCNT, 32'h0, "clear_pixcnt");
    chk("clear_s_ready", {31'd0, s_ready}, 32'd0);
    chk("clear_proc_start", {31'd0, proc_start}, 32'd0);

    // Reset mid-frame.
    wr(CTRL, 32'h1);
    run_pix(2, 8'h70, acc);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("rst2_proc_start", {31'd0, proc_start}, 32'd0);
    rd(STAT, 32'h0, "rst2_status");
    rd(FLEN, 32'h400, "rst2_framelen");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
